mc_alu: RTL

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with a valid/ready request port and a valid/ready
// result port. Simple ops finish in one cycle. MUL is an iterative shift-add
// and DIVU/REMU is a restoring divider; each takes WIDTH cycles in CALC.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload stable while valid is high and ready is
// low. out/zero/out_valid stay frozen in DONE until out_ready is seen high.
module mc_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [SW-1:0]    cnt;
    logic [3:0]       op_q;
    // acc: running product (MUL) or partial remainder (DIV)
    // sa : shifting multiplicand (MUL) or fixed divisor (DIV)
    // sb : shifting multiplier (MUL) or dividend/quotient shifter (DIV)
    logic [WIDTH-1:0] acc, sa, sb;

    logic             accept;
    logic             long_op;
    logic [WIDTH-1:0] quick;
    logic [SW-1:0]    shamt;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] calc_res;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_CALC);
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SW-1:0];
    // Divide by zero is resolved immediately, so only a nonzero divisor iterates.
    assign long_op   = (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && (b != '0));

    // Single-cycle result straight from the request inputs.
    always_comb begin
        quick = '0;
        case (op)
            OP_ADD:  quick = a + b;
            OP_SUB:  quick = a - b;
            OP_AND:  quick = a & b;
            OP_OR:   quick = a | b;
            OP_XOR:  quick = a ^ b;
            OP_SLL:  quick = a << shamt;
            OP_SRL:  quick = a >> shamt;
            OP_SRA:  quick = $signed(a) >>> shamt;
            OP_SLT:  quick = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: quick = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_DIVU: quick = '1;   // only used when b == 0
            OP_REMU: quick = a;    // only used when b == 0
            default: quick = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = acc + (sb[0] ? sa : '0);
        div_shift = {acc, sb[WIDTH-1]};
        div_diff  = div_shift - {1'b0, sa};
        div_ge    = ~div_diff[WIDTH];
        rem_n     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_n     = {sb[WIDTH-2:0], div_ge};
        calc_res  = rem_n;
        if (op_q == OP_MUL) begin
            calc_res = mul_sum;
        end else if (op_q == OP_DIVU) begin
            calc_res = quo_n;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_n = long_op ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (cnt == LAST) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_n = long_op ? S_CALC : S_DONE;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            op_q <= '0;
            acc  <= '0;
            sa   <= '0;
            sb   <= '0;
            out  <= '0;
            zero <= 1'b1;
        end else if (accept) begin
            op_q <= op;
            cnt  <= '0;
            acc  <= '0;
            if (op == OP_MUL) begin
                sa <= a;
                sb <= b;
            end else begin
                sa <= b;
                sb <= a;
            end
            if (!long_op) begin
                out  <= quick;
                zero <= (quick == '0);
            end
        end else if (state == S_CALC) begin
            cnt <= cnt + 1'b1;
            if (op_q == OP_MUL) begin
                acc <= mul_sum;
                sa  <= sa << 1;
                sb  <= sb >> 1;
            end else begin
                acc <= rem_n;
                sb  <= quo_n;
            end
            if (cnt == LAST) begin
                out  <= calc_res;
                zero <= (calc_res == '0);
            end
        end
    end

endmodule
